// File: rtl/memory_line_driver_if.sv
// memory_line_driver_if: bundles the cache-side line request port and the
// 32-bit external memory beat port of memory_line_driver into one interface.
// The master modport is the driver's view; slave is the environment's view.
interface memory_line_driver_if;
    // Cache side
    logic         DRIVER_REQ;
    logic [25:0]  DRIVER_ADDRESS;
    logic [127:0] DRIVER_WDATA;
    logic         DRIVER_RW;
    logic [127:0] DRIVER_RDATA;
    logic         DRIVER_PENDING;
    // Memory side
    logic [27:0]  MEM_ADDRESS;
    logic [31:0]  MEM_WDATA;
    logic         MEM_RW;
    logic         MEM_REQ;
    logic [31:0]  MEM_RDATA;
    logic         MEM_ACK;
    // Status
    logic         ERROR;

    modport master (
        input  DRIVER_REQ, DRIVER_ADDRESS, DRIVER_WDATA, DRIVER_RW,
        input  MEM_RDATA, MEM_ACK,
        output DRIVER_RDATA, DRIVER_PENDING,
        output MEM_ADDRESS, MEM_WDATA, MEM_RW, MEM_REQ,
        output ERROR
    );

    modport slave (
        output DRIVER_REQ, DRIVER_ADDRESS, DRIVER_WDATA, DRIVER_RW,
        output MEM_RDATA, MEM_ACK,
        input  DRIVER_RDATA, DRIVER_PENDING,
        input  MEM_ADDRESS, MEM_WDATA, MEM_RW, MEM_REQ,
        input  ERROR
    );
endinterface

// File: rtl/memory_line_driver.sv
// memory_line_driver: moves one 128-bit cache line to/from a 32-bit word
// memory as four req/ack beats. The cache is held off with DRIVER_PENDING for
// the whole transfer; the assembled read line appears on DRIVER_RDATA at the
// edge that completes the last beat.
// Optional feature: define MEM_LINE_TIMEOUT_EN to abort a beat that waits
// TIMEOUT_CYCLES cycles without MEM_ACK and raise a sticky ERROR flag.
module memory_line_driver #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    memory_line_driver_if.master  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [25:0]  line_q,  line_d;
    logic [127:0] wbuf_q,  wbuf_d;
    logic         rw_q,    rw_d;
    logic [1:0]   beat_q,  beat_d;
    logic [127:0] asm_q,   asm_d;
    logic [127:0] rdata_q, rdata_d;
    logic         req_q,   req_d;
    logic [31:0]  wdata_q, wdata_d;
    logic [1:0]   beat_nx;

`ifdef MEM_LINE_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0]  tmo_q,   tmo_d;
    logic         error_q, error_d;
`endif

    assign beat_nx = beat_q + 2'd1;

    // Next-state logic: accept a line request in IDLE, step beats on MEM_ACK in XFER
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        wbuf_d  = wbuf_q;
        rw_d    = rw_q;
        beat_d  = beat_q;
        asm_d   = asm_q;
        rdata_d = rdata_q;
        req_d   = req_q;
        wdata_d = wdata_q;
`ifdef MEM_LINE_TIMEOUT_EN
        tmo_d   = tmo_q;
        error_d = error_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.DRIVER_REQ) begin
                    state_d = XFER;
                    line_d  = bus.DRIVER_ADDRESS;
                    wbuf_d  = bus.DRIVER_WDATA;
                    rw_d    = bus.DRIVER_RW;
                    beat_d  = 2'd0;
                    req_d   = 1'b1;
                    wdata_d = bus.DRIVER_WDATA[31:0];
`ifdef MEM_LINE_TIMEOUT_EN
                    tmo_d   = 16'd0;
`endif
                end
            end
            XFER: begin
                if (bus.MEM_ACK) begin
`ifdef MEM_LINE_TIMEOUT_EN
                    tmo_d = 16'd0;
`endif
                    if (!rw_q) begin
                        asm_d[{beat_q, 5'b00000} +: 32] = bus.MEM_RDATA;
                    end
                    if (beat_q == 2'd3) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                        // Final word goes straight into the published line
                        if (!rw_q) begin
                            rdata_d = {bus.MEM_RDATA, asm_q[95:0]};
                        end
                    end else begin
                        beat_d  = beat_nx;
                        wdata_d = wbuf_q[{beat_nx, 5'b00000} +: 32];
                    end
                end else begin
`ifdef MEM_LINE_TIMEOUT_EN
                    // This wait cycle is the TIMEOUT_CYCLES-th one: abort
                    if (tmo_q == TMO_LIMIT - 16'd1) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                        error_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            line_q  <= '0;
            wbuf_q  <= '0;
            rw_q    <= 1'b0;
            beat_q  <= 2'd0;
            asm_q   <= '0;
            rdata_q <= '0;
            req_q   <= 1'b0;
            wdata_q <= '0;
`ifdef MEM_LINE_TIMEOUT_EN
            tmo_q   <= '0;
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            wbuf_q  <= wbuf_d;
            rw_q    <= rw_d;
            beat_q  <= beat_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            wdata_q <= wdata_d;
`ifdef MEM_LINE_TIMEOUT_EN
            tmo_q   <= tmo_d;
            error_q <= error_d;
`endif
        end
    end

    assign bus.MEM_REQ        = req_q;
    assign bus.MEM_ADDRESS    = {line_q, beat_q};
    assign bus.MEM_WDATA      = wdata_q;
    assign bus.MEM_RW         = rw_q;
    assign bus.DRIVER_RDATA   = rdata_q;
    // Busy already in the strobe cycle so the cache never issues a second request
    assign bus.DRIVER_PENDING = (state_q == XFER) | bus.DRIVER_REQ;
`ifdef MEM_LINE_TIMEOUT_EN
    assign bus.ERROR          = error_q;
`else
    assign bus.ERROR          = 1'b0;
`endif

endmodule

// File: tb/tb_memory_line_driver.sv
// tb_memory_line_driver: directed and randomized line transfers against a
// word-addressed memory model with programmable per-beat ACK delay.
module tb_memory_line_driver;

    localparam int TMO = 4;

    logic CLK = 1'b0;
    logic RST;

    memory_line_driver_if bus ();

    memory_line_driver #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Memory model: word address -> word; unwritten words have a fixed pattern
    logic [31:0] mem [logic [27:0]];
    logic [27:0] rd_log [$];
    logic [59:0] wr_log [$];
    int          ack_delay = 0;
    bit          ack_stuck = 0;
    bit          ack_idle  = 0;

    logic [127:0] exp_rdata;
    logic         exp_err;

    function automatic logic [31:0] mem_rd(input logic [27:0] a);
        if (mem.exists(a)) return mem[a];
        return {4'hC, a} ^ 32'h0F0F_5A5A;
    endfunction

    function automatic logic [127:0] line_of(input logic [25:0] l);
        return {mem_rd({l, 2'd3}), mem_rd({l, 2'd2}), mem_rd({l, 2'd1}), mem_rd({l, 2'd0})};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder: decides MEM_ACK/MEM_RDATA for the coming edge
    initial begin : responder
        int          wcnt;
        bit          waiting;
        logic [27:0] la;
        logic [31:0] lw;
        logic        lrw;
        wcnt = 0; waiting = 0; la = '0; lw = '0; lrw = 1'b0;
        bus.MEM_ACK   = 1'b0;
        bus.MEM_RDATA = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (waiting && bus.MEM_REQ) begin
                chk("hold_addr",  bus.MEM_ADDRESS, la);
                chk("hold_wdata", bus.MEM_WDATA, lw);
                chk("hold_rw",    bus.MEM_RW, lrw);
            end
            waiting = 0;
            bus.MEM_RDATA = $urandom;
            if (bus.MEM_REQ && !ack_stuck) begin
                if (wcnt >= ack_delay) begin
                    bus.MEM_ACK = 1'b1;
                    wcnt = 0;
                    if (bus.MEM_RW) begin
                        wr_log.push_back({bus.MEM_ADDRESS, bus.MEM_WDATA});
                        mem[bus.MEM_ADDRESS] = bus.MEM_WDATA;
                    end else begin
                        rd_log.push_back(bus.MEM_ADDRESS);
                        bus.MEM_RDATA = mem_rd(bus.MEM_ADDRESS);
                    end
                end else begin
                    bus.MEM_ACK = 1'b0;
                    wcnt++;
                    waiting = 1;
                end
            end else if (bus.MEM_REQ) begin
                bus.MEM_ACK = 1'b0;
                waiting = 1;
            end else begin
                bus.MEM_ACK = ack_idle;
                wcnt = 0;
            end
            la  = bus.MEM_ADDRESS;
            lw  = bus.MEM_WDATA;
            lrw = bus.MEM_RW;
        end
    end

    // One line transfer, started in the current cycle (call just after a negedge);
    // returns at the first negedge where PENDING is low again.
    task automatic xfer(input logic [25:0] a, input logic [127:0] wd, input bit rw,
                        input int exp_cyc, input bit abort, input bit inject);
        logic [127:0] exp_line;
        int cyc;
        bit done;
        int n;
        exp_line = line_of(a);
        rd_log.delete();
        wr_log.delete();
        bus.DRIVER_ADDRESS = a;
        bus.DRIVER_WDATA   = wd;
        bus.DRIVER_RW      = rw;
        bus.DRIVER_REQ     = 1'b1;
        #1;
        chk("pend_strobe", bus.DRIVER_PENDING, 1'b1);
        @(posedge CLK);
        #2;
        bus.DRIVER_REQ     = 1'b0;
        bus.DRIVER_ADDRESS = $urandom;
        bus.DRIVER_WDATA   = {$urandom, $urandom, $urandom, $urandom};
        bus.DRIVER_RW      = ~rw;
        chk("first_addr", bus.MEM_ADDRESS, {a, 2'b00});
        chk("mem_rw", bus.MEM_RW, rw);
        if (rw) chk("first_wdata", bus.MEM_WDATA, wd[31:0]);
        cyc = 1;
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge CLK);
            if (bus.DRIVER_PENDING) begin
                cyc++;
                chk("busy_req",  bus.MEM_REQ, 1'b1);
                chk("busy_line", bus.MEM_ADDRESS[27:2], a);
            end else begin
                done = 1;
            end
            if (inject && cyc == 3) begin
                bus.DRIVER_REQ = 1'b1;
                bus.DRIVER_ADDRESS = ~a;
            end else if (inject && cyc == 4) begin
                bus.DRIVER_REQ = 1'b0;
            end
        end
        if (!done) chk("pending_bound", bus.DRIVER_PENDING, 1'b0);
        chk("latency", cyc, exp_cyc);
        chk("idle_memreq", bus.MEM_REQ, 1'b0);
        if (abort) exp_err = 1'b1;
        chk("error", bus.ERROR, exp_err);
        if (!abort && !rw) exp_rdata = exp_line;
        chk("rdata", bus.DRIVER_RDATA, exp_rdata);
        if (!abort) begin
            n = rw ? wr_log.size() : rd_log.size();
            chk("beat_count", n, 4);
            for (int i = 0; i < 4 && i < n; i++) begin
                if (rw) chk("wr_beat", wr_log[i], {a, 2'(i), wd[32*i +: 32]});
                else    chk("rd_beat", rd_log[i], {a, 2'(i)});
            end
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [25:0]  a, last_a;
        logic [127:0] wd;
        bit           rw;
        int           d;
        RST = 1'b1;
        bus.DRIVER_REQ = 1'b0;
        bus.DRIVER_ADDRESS = '0;
        bus.DRIVER_WDATA = '0;
        bus.DRIVER_RW = 1'b0;
        exp_rdata = '0;
        exp_err = 1'b0;
        last_a = 26'h123;

        // Reset state
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_memreq", bus.MEM_REQ, 1'b0);
        chk("rst_addr",   bus.MEM_ADDRESS, 28'h0);
        chk("rst_wdata",  bus.MEM_WDATA, 32'h0);
        chk("rst_rw",     bus.MEM_RW, 1'b0);
        chk("rst_rdata",  bus.DRIVER_RDATA, 128'h0);
        chk("rst_error",  bus.ERROR, 1'b0);
        chk("rst_pend",   bus.DRIVER_PENDING, 1'b0);
        bus.DRIVER_REQ = 1'b1;
        #1;
        chk("rst_pend_req", bus.DRIVER_PENDING, 1'b1);
        bus.DRIVER_REQ = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // MEM_ACK in IDLE is ignored
        ack_idle = 1;
        repeat (3) @(negedge CLK);
        chk("idle_ack_req",   bus.MEM_REQ, 1'b0);
        chk("idle_ack_pend",  bus.DRIVER_PENDING, 1'b0);
        chk("idle_ack_rdata", bus.DRIVER_RDATA, 128'h0);
        ack_idle = 0;
        @(negedge CLK);

        // Read of line 0x123 with words A0000000+i, ACK always high
        for (int i = 0; i < 4; i++) mem[{26'h123, 2'(i)}] = 32'hA000_0000 + i;
        ack_delay = 0;
        xfer(26'h123, 128'h0, 1'b0, 5, 1'b0, 1'b0);
        chk("tp_read", bus.DRIVER_RDATA, 128'hA0000003_A0000002_A0000001_A0000000);

        // Write with two wait cycles per beat: 13 cycles pending
        ack_delay = 2;
        xfer(26'h2AA, 128'h44444444_33333333_22222222_11111111, 1'b1, 13, 1'b0, 1'b0);

        // Write immediately followed by read of the same line (with ignored strobe mid-write)
        wd = {$urandom, $urandom, $urandom, $urandom};
        ack_delay = 1;
        xfer(26'h0ABCDE, wd, 1'b1, 9, 1'b0, 1'b1);
        ack_delay = 0;
        xfer(26'h0ABCDE, 128'h0, 1'b0, 5, 1'b0, 1'b0);
        chk("readback", bus.DRIVER_RDATA, wd);

        // Randomized transfers
        for (int t = 0; t < 10; t++) begin
            a  = ($urandom_range(0, 1) == 1) ? last_a : 26'($urandom);
            rw = bit'($urandom_range(0, 1));
            d  = $urandom_range(0, 3);
            wd = {$urandom, $urandom, $urandom, $urandom};
            ack_delay = d;
            xfer(a, wd, rw, 1 + 4 * (d + 1), 1'b0, bit'($urandom_range(0, 1)));
            last_a = a;
        end

        // Reset during beat 2 of a read
        ack_delay = 0;
        a = 26'h3F00001;
        bus.DRIVER_ADDRESS = a;
        bus.DRIVER_RW = 1'b0;
        bus.DRIVER_REQ = 1'b1;
        @(posedge CLK);
        #2;
        bus.DRIVER_REQ = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #2;
        chk("pre_rst_beat", bus.MEM_ADDRESS, {a, 2'd2});
        #1;
        RST = 1'b1;
        #1;
        chk("mid_rst_memreq", bus.MEM_REQ, 1'b0);
        chk("mid_rst_rdata",  bus.DRIVER_RDATA, 128'h0);
        chk("mid_rst_addr",   bus.MEM_ADDRESS, 28'h0);
        chk("mid_rst_pend",   bus.DRIVER_PENDING, 1'b0);
        exp_rdata = '0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_idle", bus.MEM_REQ, 1'b0);
        xfer(a, 128'h0, 1'b0, 5, 1'b0, 1'b0);

        // MEM_ACK stuck low
`ifdef MEM_LINE_TIMEOUT_EN
        ack_stuck = 1;
        xfer(26'h1234567, 128'h0, 1'b0, 1 + TMO, 1'b1, 1'b0);
        ack_stuck = 0;
        xfer(26'h0000777, 128'h0, 1'b0, 5, 1'b0, 1'b0);
        wd = {$urandom, $urandom, $urandom, $urandom};
        xfer(26'h0000778, wd, 1'b1, 5, 1'b0, 1'b0);
`else
        ack_stuck = 1;
        bus.DRIVER_ADDRESS = 26'h1234567;
        bus.DRIVER_RW = 1'b0;
        bus.DRIVER_REQ = 1'b1;
        @(posedge CLK);
        #2;
        bus.DRIVER_REQ = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            chk("stuck_req",  bus.MEM_REQ, 1'b1);
            chk("stuck_err",  bus.ERROR, 1'b0);
            chk("stuck_pend", bus.DRIVER_PENDING, 1'b1);
        end
        RST = 1'b1;
        #1;
        chk("stuck_rst_req", bus.MEM_REQ, 1'b0);
        exp_rdata = '0;
        @(negedge CLK);
        RST = 1'b0;
        ack_stuck = 0;
        @(negedge CLK);
        xfer(26'h0000777, 128'h0, 1'b0, 5, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
